e_acs_213: RTL and testbench

Add-Compare-Select and path-metric unit for the (2,1,3) backward-label Viterbi decoder. It consumes the sixteen 2-bit branch metrics produced combinationally by the branch metric unit for each received symbol pair. It updates eight path metrics once per valid symbol and emits one 8-bit survivor-decision word per symbol to the downstream traceback/survivor memory.

---
 rtl/e_acs_213_pkg.sv | 39 +++
 rtl/e_acs_213_if.sv | 17 +
 rtl/e_acs_213_cell.sv | 25 ++
 rtl/e_acs_213.sv | 104 ++++++++++
 tb/tb_e_acs_213.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/e_acs_213_pkg.sv
// e213_pkg: shared constants and helpers for the (2,1,3) Viterbi ACS unit.
//   NUM_STATES / HD_W  : trellis size and branch-metric width
//   p0 / p1            : predecessor states of a next state s'
//   bm0_idx / bm1_idx  : 0-based HD index for the p0 / p1 branch into s'
//   init_vec           : frame-start metric vector {0, bias x7}
package e213_pkg;
  localparam int NUM_STATES = 8;
  localparam int HD_W       = 2;
  localparam int NUM_HD     = 2 * NUM_STATES;
  localparam int PM_MAX_W   = 16;

  typedef logic [NUM_HD-1:0][HD_W-1:0] hd_vec_t;

  // s' = {u, s[2:1]}, so both predecessors share s'[1:0] as their upper bits
  function automatic logic [2:0] p0(input logic [2:0] s);
    return {s[1:0], 1'b0};
  endfunction

  function automatic logic [2:0] p1(input logic [2:0] s);
    return {s[1:0], 1'b1};
  endfunction

  // HD(2s'+1) / HD(2s'+2) in 1-based numbering
  function automatic int bm0_idx(input int s);
    return 2 * s;
  endfunction

  function automatic int bm1_idx(input int s);
    return 2 * s + 1;
  endfunction

  // Wide so it is usable for any PM_W; callers keep the low PM_W bits
  function automatic logic [NUM_STATES-1:0][PM_MAX_W-1:0] init_vec(input int unsigned bias);
    logic [NUM_STATES-1:0][PM_MAX_W-1:0] r;
    r = '0;
    for (int s = 1; s < NUM_STATES; s++) r[s] = PM_MAX_W'(bias);
    return r;
  endfunction
endpackage

// File: rtl/e_acs_213_if.sv
// e_acs_213_if: BMU -> ACS -> survivor-memory bus.
//   sym_valid, init, hd[16]       : driven by the BMU side (master)
//   decision[8], dec_valid, best_state : driven by the ACS (slave)
// hd[0] carries HD1, hd[15] carries HD16.
interface e_acs_213_if;
  logic                sym_valid;
  logic                init;
  e213_pkg::hd_vec_t   hd;
  logic [7:0]          decision;
  logic                dec_valid;
  logic [2:0]          best_state;

  modport master (output sym_valid, init, hd,
                  input  decision, dec_valid, best_state);
  modport slave  (input  sym_valid, init, hd,
                  output decision, dec_valid, best_state);
endinterface

// File: rtl/e_acs_213_cell.sv
// e_acs_cell_213: one add-compare-select cell.
//   pm0_i/pm1_i : metrics of predecessors p0/p1
//   bm0_i/bm1_i : branch metrics on the p0/p1 branches
//   pm_o        : surviving metric (fits PM_W bits by construction)
//   dec_o       : 1 when the p1 branch wins; ties go to p0
module e_acs_cell_213
  import e213_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [HD_W-1:0] bm0_i,
  input  logic [HD_W-1:0] bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);
  logic [PM_W:0] c0, c1;

  // One extra bit so the compare is exact even if a sum would wrap PM_W
  assign c0    = {1'b0, pm0_i} + (PM_W+1)'(bm0_i);
  assign c1    = {1'b0, pm1_i} + (PM_W+1)'(bm1_i);
  assign dec_o = (c1 < c0);
  assign pm_o  = dec_o ? c1[PM_W-1:0] : c0[PM_W-1:0];
endmodule

// File: rtl/e_acs_213.sv
// e_acs_213: ACS and path-metric unit for the (2,1,3) Viterbi decoder.
//   clk_i, rst_i : clock, async active-high reset
//   acs          : e_acs_213_if.slave (sym_valid/init/hd in,
//                  decision/dec_valid/best_state out)
// Optional feature: E213_BEST_STATE_EN builds the min-metric search and
// registers best_state; otherwise best_state is tied to 0.
// One symbol per cycle, one cycle latency, no back-pressure.
module e_acs_213
  import e213_pkg::*;
#(
  parameter int PM_W      = 6,
  parameter int INIT_BIAS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  e_acs_213_if.slave   acs
);
  localparam logic [NUM_STATES-1:0][PM_MAX_W-1:0] INIT_WIDE = init_vec(INIT_BIAS);

  logic [NUM_STATES-1:0][PM_W-1:0] init_pm;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_q;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_src;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_new;
  logic [NUM_STATES-1:0][PM_W-1:0] pm_d;
  logic [NUM_STATES-1:0]           dec_d, dec_q;
  logic [NUM_STATES-1:0]           msb;
  logic                            norm;
  logic                            dv_q;

  // Init swaps the ACS source to the frame-start vector
  assign pm_src = acs.init ? init_pm : pm_q;

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_st
    assign init_pm[s] = INIT_WIDE[s][PM_W-1:0];

    e_acs_cell_213 #(.PM_W(PM_W)) u_cell (
      .pm0_i (pm_src[p0(3'(s))]),
      .pm1_i (pm_src[p1(3'(s))]),
      .bm0_i (acs.hd[bm0_idx(s)]),
      .bm1_i (acs.hd[bm1_idx(s)]),
      .pm_o  (pm_new[s]),
      .dec_o (dec_d[s])
    );

    assign msb[s] = pm_new[s][PM_W-1];
  end

  // Bounded spread keeps metrics within 2^PM_W; once every metric has the
  // top bit set it carries no information and is dropped from all of them.
  assign norm = &msb;

  always_comb begin
    pm_d = pm_new;
    if (norm) begin
      for (int s = 0; s < NUM_STATES; s++) pm_d[s][PM_W-1] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pm_q  <= init_pm;
      dec_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      dv_q <= acs.sym_valid;
      if (acs.sym_valid) begin
        pm_q  <= pm_d;
        dec_q <= dec_d;
      end else if (acs.init) begin
        pm_q  <= init_pm;
      end
    end
  end

  assign acs.decision  = dec_q;
  assign acs.dec_valid = dv_q;

`ifdef E213_BEST_STATE_EN
  logic [2:0]      best_d, best_q;
  logic [PM_W-1:0] best_v;

  // Strict compare keeps the lowest index on ties; normalization shifts all
  // metrics equally so searching the stored values is order-preserving.
  always_comb begin
    best_d = 3'd0;
    best_v = pm_d[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (pm_d[s] < best_v) begin
        best_d = 3'(s);
        best_v = pm_d[s];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              best_q <= 3'd0;
    else if (acs.sym_valid) best_q <= best_d;
  end

  assign acs.best_state = best_q;
`else
  assign acs.best_state = 3'd0;
`endif
endmodule

// File: tb/tb_e_acs_213.sv
// tb_e_acs_213: directed self-checking bench for e_acs_213 (PM_W=6, INIT_BIAS=4).
module tb_e_acs_213;
  localparam int PM_W = 6;
`ifdef E213_BEST_STATE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  e_acs_213_if bus ();

  e_acs_213 #(.PM_W(PM_W), .INIT_BIAS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .acs   (bus.slave)
  );

  int v1[16]  = '{0,2,1,1,2,0,1,1,2,0,1,1,0,2,1,1};
  int vone[16] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
  int vtwo[16] = '{2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,2};
  int v3[16]  = '{3,3,3,3,0,3,3,3,3,3,3,3,0,3,3,0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int v[16]);
    for (int i = 0; i < 16; i++) bus.hd[i] = 2'(v[i]);
  endtask

  function automatic logic [47:0] pmv(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] dec, input logic dv,
                         input logic [2:0] best, input logic [47:0] pm);
    chk({tag, ".dec"},  bus.decision,   dec);
    chk({tag, ".dv"},   bus.dec_valid,  dv);
    chk({tag, ".best"}, bus.best_state, BS_EN ? best : 3'd0);
    chk({tag, ".pm"},   dut.pm_q,       pm);
  endtask

  int g[8], gn[8];
  int off, mn;
  logic [7:0] gdec;

  initial begin
    rst = 1'b1;
    bus.sym_valid = 1'b0;
    bus.init = 1'b0;
    bus.hd = '0;
    #2;
    chk_out("reset", 8'h00, 1'b0, 3'd0, pmv(0,4,4,4,4,4,4,4));
    #10 rst = 1'b0;  // t=12, away from edges

    // single symbol from reset metrics
    bus.sym_valid = 1'b1;
    load(v1);
    tick();
    chk_out("sym1", 8'h04, 1'b1, 3'd0, pmv(0,5,4,5,2,5,4,5));
    bus.sym_valid = 1'b0;
    tick();
    chk_out("hold", 8'h04, 1'b0, 3'd0, pmv(0,5,4,5,2,5,4,5));

    // ties from reset metrics, then a back-to-back symbol with a p1 win
    rst = 1'b1; #1 rst = 1'b0;
    bus.sym_valid = 1'b1;
    load(vone);
    tick();
    chk_out("tie", 8'h00, 1'b1, 3'd0, pmv(1,5,5,5,1,5,5,5));
    load(v3);
    tick();
    chk_out("b2b", 8'h80, 1'b1, 3'd2, pmv(4,8,1,8,4,8,1,5));

    // init alone then idle
    bus.sym_valid = 1'b0;
    bus.init = 1'b1;
    tick();
    chk("init.dv", bus.dec_valid, 1'b0);
    chk("init.pm", dut.pm_q, pmv(0,4,4,4,4,4,4,4));
    bus.init = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("idle.dv", bus.dec_valid, 1'b0);
      chk("idle.pm", dut.pm_q, pmv(0,4,4,4,4,4,4,4));
    end

    // 40 symbols of HD=2 against an unbounded model
    g = '{0,4,4,4,4,4,4,4};
    off = 0;
    bus.sym_valid = 1'b1;
    load(vtwo);
    for (int k = 0; k < 40; k++) begin
      for (int s = 0; s < 8; s++) begin
        int a, b;
        a = g[(s % 4) * 2] + 2;
        b = g[(s % 4) * 2 + 1] + 2;
        gdec[s] = (b < a);
        gn[s] = (b < a) ? b : a;
      end
      g = gn;
      mn = g[0];
      for (int s = 1; s < 8; s++) if (g[s] < mn) mn = g[s];
      if (mn - off >= 32) off += 32;
      tick();
      chk("norm.dec", bus.decision, gdec);
      chk("norm.pm", dut.pm_q, pmv(g[0]-off, g[1]-off, g[2]-off, g[3]-off,
                                   g[4]-off, g[5]-off, g[6]-off, g[7]-off));
      mn = 63;
      for (int s = 0; s < 8; s++) if (int'(dut.pm_q[s]) < mn) mn = int'(dut.pm_q[s]);
      chk("norm.min", (mn <= 33), 1'b1);
    end
    chk("norm.hit", (off >= 64), 1'b1);

    // init with symbol mid-frame ignores stored metrics
    bus.init = 1'b1;
    load(v1);
    tick();
    chk_out("initsym", 8'h04, 1'b1, 3'd0, pmv(0,5,4,5,2,5,4,5));

    // reset between two back-to-back symbols
    tick();
    chk("pre_rst.dv", bus.dec_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 3'd0, pmv(0,4,4,4,4,4,4,4));
    bus.init = 1'b0;
    load(vone);
    #1 rst = 1'b0;
    tick();
    chk_out("post_rst", 8'h00, 1'b1, 3'd0, pmv(1,5,5,5,1,5,5,5));
    bus.sym_valid = 1'b0;
    tick();
    chk("end.dv", bus.dec_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
